// File: rtl/proc_run_controller.sv
// rtl/proc_run_controller.sv - program load and run sequencing for the 4-bit-PC core
// Streams program bytes into instruction memory, then gates core execution via core_en/core_rst.
module proc_run_controller #(
   parameter int IMEM_DEPTH = 16,
   parameter int ADDR_W     = 4,
   parameter int CYC_W      = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd,
   input  logic [CYC_W-1:0]  cmd_arg,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [7:0]        ld_data,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [7:0]        imem_wdata,
   output logic              core_en,
   output logic              core_rst,
   output logic              busy,
   output logic              done,
   output logic [CYC_W-1:0]  cycles
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_STEP,
      S_DONE
   } state_t;

   localparam logic [1:0]        CMD_LOAD  = 2'b00;
   localparam logic [1:0]        CMD_RUN   = 2'b01;
   localparam logic [1:0]        CMD_STEP  = 2'b10;
   localparam logic [1:0]        CMD_HALT  = 2'b11;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);
   localparam logic [CYC_W-1:0]  CYC_MAX   = {CYC_W{1'b1}};

   state_t            r_state;
   logic [ADDR_W-1:0] r_ptr;
   logic [CYC_W-1:0]  r_remain;
   logic              r_free;
   logic              r_load_exit;
   logic              r_imem_we;
   logic [ADDR_W-1:0] r_imem_waddr;
   logic [7:0]        r_imem_wdata;
   logic              r_core_en;
   logic              r_core_rst;
   logic              r_busy;
   logic              r_done;
   logic [CYC_W-1:0]  r_cycles;

   state_t            w_state_nxt;
   logic [ADDR_W-1:0] w_ptr_nxt;
   logic [CYC_W-1:0]  w_remain_nxt;
   logic              w_free_nxt;
   logic              w_load_exit_nxt;
   logic              w_we_nxt;
   logic [ADDR_W-1:0] w_waddr_nxt;
   logic [7:0]        w_wdata_nxt;
   logic              w_core_en_nxt;
   logic              w_core_rst_nxt;
   logic              w_busy_nxt;
   logic              w_done_nxt;
   logic [CYC_W-1:0]  w_cycles_nxt;
   logic              w_cmd_hs;
   logic              w_ld_hs;
   logic              w_halt_hs;

   assign cmd_ready = rst_n & ((r_state == S_IDLE) | (r_state == S_LOAD) | (r_state == S_RUN));
   assign ld_ready  = rst_n & (r_state == S_LOAD);
   assign w_cmd_hs  = cmd_valid & cmd_ready;
   assign w_ld_hs   = ld_valid & ld_ready;
   assign w_halt_hs = w_cmd_hs & (cmd == CMD_HALT);

   assign imem_we    = r_imem_we;
   assign imem_waddr = r_imem_waddr;
   assign imem_wdata = r_imem_wdata;
   assign core_en    = r_core_en;
   assign core_rst   = r_core_rst;
   assign busy       = r_busy;
   assign done       = r_done;
   assign cycles     = r_cycles;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_remain     <= '0;
         r_free       <= 1'b0;
         r_load_exit  <= 1'b0;
         r_imem_we    <= 1'b0;
         r_imem_waddr <= '0;
         r_imem_wdata <= '0;
         r_core_en    <= 1'b0;
         r_core_rst   <= 1'b1;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_cycles     <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_ptr        <= w_ptr_nxt;
         r_remain     <= w_remain_nxt;
         r_free       <= w_free_nxt;
         r_load_exit  <= w_load_exit_nxt;
         r_imem_we    <= w_we_nxt;
         r_imem_waddr <= w_waddr_nxt;
         r_imem_wdata <= w_wdata_nxt;
         r_core_en    <= w_core_en_nxt;
         r_core_rst   <= w_core_rst_nxt;
         r_busy       <= w_busy_nxt;
         r_done       <= w_done_nxt;
         r_cycles     <= w_cycles_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_remain_nxt = r_remain;
      w_free_nxt   = r_free;
      w_we_nxt     = 1'b0;
      w_waddr_nxt  = r_imem_waddr;
      w_wdata_nxt  = r_imem_wdata;
      // core_en in the current cycle means the core executed this cycle
      w_cycles_nxt = (r_core_en && (r_cycles != CYC_MAX)) ? r_cycles + 1'b1 : r_cycles;

      case (r_state)
         S_IDLE: begin
            if (w_cmd_hs) begin
               case (cmd)
                  CMD_LOAD: begin
                     w_state_nxt  = S_LOAD;
                     w_ptr_nxt    = '0;
                     w_cycles_nxt = '0;
                  end
                  CMD_RUN: begin
                     w_state_nxt  = S_RUN;
                     w_remain_nxt = cmd_arg;
                     w_free_nxt   = (cmd_arg == '0);
                  end
                  CMD_STEP: w_state_nxt = S_STEP;
                  default:  w_state_nxt = S_DONE;
               endcase
            end
         end
         S_LOAD: begin
            if (w_ld_hs) begin
               w_we_nxt    = 1'b1;
               w_waddr_nxt = r_ptr;
               w_wdata_nxt = ld_data;
               w_ptr_nxt   = r_ptr + 1'b1;
               if (r_ptr == LAST_ADDR) begin
                  w_state_nxt = S_DONE;
               end
            end
            if (w_halt_hs) begin
               w_state_nxt = S_DONE;
            end
         end
         S_RUN: begin
            if (w_halt_hs) begin
               w_state_nxt = S_DONE;
            end else if (!r_free) begin
               if (r_remain <= 1) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_remain_nxt = r_remain - 1'b1;
               end
            end
         end
         S_STEP:  w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase

      w_core_en_nxt   = (w_state_nxt == S_RUN) || (w_state_nxt == S_STEP);
      w_busy_nxt      = (w_state_nxt == S_LOAD) || (w_state_nxt == S_RUN) || (w_state_nxt == S_STEP);
      w_done_nxt      = (w_state_nxt == S_DONE);
      w_load_exit_nxt = (r_state == S_LOAD) && (w_state_nxt != S_LOAD);

      // core reset holds through the DONE cycle after a load and drops on the next one
      if (w_state_nxt == S_LOAD) begin
         w_core_rst_nxt = 1'b1;
      end else if (r_load_exit) begin
         w_core_rst_nxt = 1'b0;
      end else begin
         w_core_rst_nxt = r_core_rst;
      end
   end

endmodule
